alu_op_sequencer: RTL and testbench

Registered, handshaked successor to the combinational ALU control decoder. It accepts one decoded instruction per transfer (ALUOp, func, shift amount) and issues a stream of ALU micro-operations to the datapath ALU. Single-cycle ops issue as one beat. Shift and rotate ops by N bits issue as N single-bit beats. It sits between the main control unit / register-read stage and the ALU, and provides backpressure so multi-cycle shifts stall the front end.

---
 rtl/alu_pkg.sv | 75 +++++++
 rtl/alu_func_decode.sv | 32 +++
 rtl/alu_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, func codes, alu_op encodings,
// sequencer state type and the alu_op/func decode function.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0011;
  localparam logic [3:0] OP_SRS = 4'b0100;
  localparam logic [3:0] OP_URS = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_ROR = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000100;
  localparam logic [5:0] FN_OR  = 6'b000101;
  localparam logic [5:0] FN_SLT = 6'b001010;
  localparam logic [5:0] FN_LS  = 6'b111101;
  localparam logic [5:0] FN_SRS = 6'b111010;
  localparam logic [5:0] FN_URS = 6'b111001;
  localparam logic [5:0] FN_ROR = 6'b111011;
  localparam logic [5:0] FN_ROL = 6'b111110;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] operation;
    logic       is_shift;
    logic       is_illegal;
  } dec_t;

  // Illegal encodings report ADD so the caller only has to override when trapping.
  function automatic dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] func);
    dec_t d;
    d.operation  = OP_ADD;
    d.is_shift   = 1'b0;
    d.is_illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: d.operation = OP_ADD;
      ALUOP_BR:  d.operation = OP_SUB;
      ALUOP_RTYPE: begin
        case (func)
          FN_ADD: d.operation = OP_ADD;
          FN_SUB: d.operation = OP_SUB;
          FN_AND: d.operation = OP_AND;
          FN_OR:  d.operation = OP_OR;
          FN_SLT: d.operation = OP_SLT;
          FN_LS:  begin d.operation = OP_LS;  d.is_shift = 1'b1; end
          FN_SRS: begin d.operation = OP_SRS; d.is_shift = 1'b1; end
          FN_URS: begin d.operation = OP_URS; d.is_shift = 1'b1; end
          FN_ROR: begin d.operation = OP_ROR; d.is_shift = 1'b1; end
          FN_ROL: begin d.operation = OP_ROL; d.is_shift = 1'b1; end
          default: d.is_illegal = 1'b1;
        endcase
      end
      ALUOP_RSVD: d.is_illegal = 1'b1;
      default:    d.is_illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: stateless alu_op/func decoder feeding the sequencer input stage.
module alu_func_decode #(
  parameter int FUNC_W = 6
) (
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic [3:0]        operation,
  output logic              is_shift,
  output logic              is_illegal
);
  import alu_pkg::*;

  logic [5:0] func6;
  logic       hi_nz;
  dec_t       dec;

  // Decode; any set bit above the 6-bit func field makes an R-type illegal.
  always_comb begin
    func6 = 6'(func);
    hi_nz = ((func >> 6) != '0);
    dec   = alu_decode(alu_op, func6);
    if (hi_nz && (alu_op == ALUOP_RTYPE)) begin
      dec.operation  = OP_ADD;
      dec.is_shift   = 1'b0;
      dec.is_illegal = 1'b1;
    end
    operation  = dec.operation;
    is_shift   = dec.is_shift;
    is_illegal = dec.is_illegal;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered, handshaked ALU control. Accepts one decoded
// instruction per transfer and issues one beat per micro-op; shifts/rotates by
// N issue N single-bit beats. Optional illegal-instruction trapping is enabled
// with the macro ALU_OP_SEQ_ILLEGAL_TRAP_EN (default: illegal decodes to ADD).
module alu_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int FUNC_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNC_W-1:0]  func,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [3:0]         operation,
  output logic               last,
  output logic [SHAMT_W-1:0] beat_idx,
  output logic               illegal,
  output logic               illegal_sticky
);
  import alu_pkg::*;

  state_t             state_q, state_d;
  logic [3:0]         operation_q, operation_d;
  logic               last_q, last_d;
  logic [SHAMT_W-1:0] beat_idx_q, beat_idx_d;
  logic [SHAMT_W-1:0] last_idx_q, last_idx_d;
  logic               illegal_q, illegal_d;
  logic               sticky_q, sticky_d;

  logic [3:0]         dec_op;
  logic               dec_shift;
  logic               dec_illegal;

  logic [3:0]         ld_op;
  logic               ld_single;
  logic [SHAMT_W-1:0] ld_last_idx;
  logic               ld_ill;
  logic               load;

  logic               accept;
  logic               beat_xfer;

  alu_func_decode #(.FUNC_W(FUNC_W)) u_dec (
    .alu_op     (alu_op),
    .func       (func),
    .operation  (dec_op),
    .is_shift   (dec_shift),
    .is_illegal (dec_illegal)
  );

  assign op_valid  = (state_q != ST_IDLE);
  assign in_ready  = !op_valid || (op_ready && last_q);
  assign accept    = in_valid && in_ready;
  assign beat_xfer = op_valid && op_ready;

  // Shape the decoded instruction into its first beat and beat count.
  always_comb begin
    ld_op       = dec_op;
    ld_single   = 1'b1;
    ld_last_idx = '0;
    ld_ill      = 1'b0;
    if (dec_illegal) begin
`ifdef ALU_OP_SEQ_ILLEGAL_TRAP_EN
      ld_op  = OP_NOP;
      ld_ill = 1'b1;
`else
      ld_op  = OP_ADD;
`endif
    end else if (dec_shift) begin
      if (shamt == '0) begin
        ld_op = OP_NOP;
      end else begin
        ld_single   = (shamt == SHAMT_W'(1));
        ld_last_idx = shamt - SHAMT_W'(1);
      end
    end
  end

  // Next-state and beat-output logic; a new instruction loads only on accept.
  always_comb begin
    state_d     = state_q;
    operation_d = operation_q;
    last_d      = last_q;
    beat_idx_d  = beat_idx_q;
    last_idx_d  = last_idx_q;
    illegal_d   = illegal_q;
    sticky_d    = sticky_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
      end
      ST_ISSUE: begin
        if (beat_xfer) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            operation_d = OP_NOP;
            last_d      = 1'b0;
            beat_idx_d  = '0;
            illegal_d   = 1'b0;
          end
        end
      end
      ST_REPEAT: begin
        if (beat_xfer) begin
          beat_idx_d = beat_idx_q + SHAMT_W'(1);
          if (beat_idx_q == (last_idx_q - SHAMT_W'(1))) begin
            state_d = ST_ISSUE;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d     = ld_single ? ST_ISSUE : ST_REPEAT;
      operation_d = ld_op;
      last_d      = ld_single;
      beat_idx_d  = '0;
      last_idx_d  = ld_last_idx;
      illegal_d   = ld_ill;
    end

`ifdef ALU_OP_SEQ_ILLEGAL_TRAP_EN
    if (accept && dec_illegal) sticky_d = 1'b1;
`endif
  end

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      operation_q <= OP_NOP;
      last_q      <= 1'b0;
      beat_idx_q  <= '0;
      last_idx_q  <= '0;
      illegal_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      operation_q <= operation_d;
      last_q      <= last_d;
      beat_idx_q  <= beat_idx_d;
      last_idx_q  <= last_idx_d;
      illegal_q   <= illegal_d;
      sticky_q    <= sticky_d;
    end
  end

  assign operation      = operation_q;
  assign last           = last_q;
  assign beat_idx       = beat_idx_q;
  assign illegal        = illegal_q;
  assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven vectors with a beat scoreboard plus
// directed multi-cycle sequences. Inputs change and outputs are sampled on
// the falling edge.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] func;
  logic [2:0] shamt;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] operation;
  logic       last;
  logic [2:0] beat_idx;
  logic       illegal;
  logic       illegal_sticky;

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_bit     = 1'b1;

`ifdef ALU_OP_SEQ_ILLEGAL_TRAP_EN
  localparam logic [3:0] ILL_OP  = 4'b1111;
  localparam logic       ILL_BIT = 1'b1;
`else
  localparam logic [3:0] ILL_OP  = 4'b0010;
  localparam logic       ILL_BIT = 1'b0;
`endif

  assign op_ready = rand_ready ? rnd_bit : ready_force;

  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  alu_op_sequencer #(.DATA_W(8), .SHAMT_W(3), .FUNC_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_op         (alu_op),
    .func           (func),
    .shamt          (shamt),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .operation      (operation),
    .last           (last),
    .beat_idx       (beat_idx),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  typedef struct {
    logic [1:0] aop;
    logic [5:0] fn;
    logic [2:0] sh;
    logic [3:0] eop;
    int         beats;
    logic       eill;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic       last;
    logic [2:0] idx;
    logic       ill;
  } beat_t;

  beat_t      sbq[$];
  vec_t       tbl[16];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cur_op;
  int         cur_beats;
  logic       cur_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop/compare any beat transferring this cycle, push beats for any accepted input.
  task automatic sb_update();
    beat_t b;
    beat_t e;
    if (!rst_n) begin
      sbq.delete();
      return;
    end
    if (op_valid && op_ready) begin
      b = '{operation, last, beat_idx, illegal};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_beat: got op=%b last=%b idx=%0d ill=%b expected no beat",
                 b.op, b.last, b.idx, b.ill);
      end else begin
        e = sbq.pop_front();
        if (b.op !== e.op || b.last !== e.last || b.idx !== e.idx || b.ill !== e.ill) begin
          errors++;
          $display("FAIL sb_beat: got op=%b last=%b idx=%0d ill=%b expected op=%b last=%b idx=%0d ill=%b",
                   b.op, b.last, b.idx, b.ill, e.op, e.last, e.idx, e.ill);
        end
      end
    end
    if (in_valid && in_ready) begin
      for (int i = 0; i < cur_beats; i++)
        sbq.push_back('{cur_op, (i == cur_beats - 1), 3'(i), cur_ill});
    end
  endtask

  task automatic cycle();
    #1;
    sb_update();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] f, input logic [2:0] s,
                      input logic [3:0] eop, input int beats, input logic eill,
                      output int waits);
    bit ok;
    waits     = 0;
    ok        = 1'b0;
    alu_op    = a;
    func      = f;
    shamt     = s;
    cur_op    = eop;
    cur_beats = beats;
    cur_ill   = eill;
    in_valid  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #1;
      ok = in_ready;
      cycle();
      if (ok) break;
      waits++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    int         n;
    logic [8:0] snap;

    tbl[0]  = '{2'b00, 6'b111111, 3'd5, 4'b0010, 1, 1'b0};
    tbl[1]  = '{2'b01, 6'b111011, 3'd7, 4'b0110, 1, 1'b0};
    tbl[2]  = '{2'b10, 6'b000000, 3'd3, 4'b0010, 1, 1'b0};
    tbl[3]  = '{2'b10, 6'b000010, 3'd0, 4'b0110, 1, 1'b0};
    tbl[4]  = '{2'b10, 6'b000100, 3'd0, 4'b0000, 1, 1'b0};
    tbl[5]  = '{2'b10, 6'b000101, 3'd0, 4'b0001, 1, 1'b0};
    tbl[6]  = '{2'b10, 6'b001010, 3'd0, 4'b0111, 1, 1'b0};
    tbl[7]  = '{2'b10, 6'b111101, 3'd2, 4'b0011, 2, 1'b0};
    tbl[8]  = '{2'b10, 6'b111010, 3'd1, 4'b0100, 1, 1'b0};
    tbl[9]  = '{2'b10, 6'b111001, 3'd4, 4'b0101, 4, 1'b0};
    tbl[10] = '{2'b10, 6'b111011, 3'd3, 4'b1000, 3, 1'b0};
    tbl[11] = '{2'b10, 6'b111110, 3'd6, 4'b1001, 6, 1'b0};
    tbl[12] = '{2'b10, 6'b111110, 3'd0, 4'b1111, 1, 1'b0};
    tbl[13] = '{2'b10, 6'b000001, 3'd4, ILL_OP,  1, ILL_BIT};
    tbl[14] = '{2'b11, 6'b111101, 3'd3, ILL_OP,  1, ILL_BIT};
    tbl[15] = '{2'b10, 6'b111101, 3'd7, 4'b0011, 7, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    alu_op   = 2'b00;
    func     = 6'b0;
    shamt    = 3'd0;
    @(negedge clk);
    repeat (3) cycle();
    chk("reset_state", 32'({op_valid, in_ready, operation, last, beat_idx, illegal, illegal_sticky}),
        32'({1'b0, 1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    cycle();

    // AND: first beat one edge after acceptance
    send(2'b10, 6'b000100, 3'd0, 4'b0000, 1, 1'b0, w);
    chk("and_first_beat", 32'({op_valid, operation, last, beat_idx}),
        32'({1'b1, 4'b0000, 1'b1, 3'd0}));
    cycle();
    chk("and_then_idle", 32'(op_valid), 32'(1'b0));

    // ROR by 5: five beats, in_ready low for four cycles
    send(2'b10, 6'b111011, 3'd5, 4'b1000, 5, 1'b0, w);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      n++;
      cycle();
    end
    chk("ror_in_ready_low_cycles", 32'(n), 32'(4));
    chk("ror_final_beat", 32'({operation, last, beat_idx}), 32'({4'b1000, 1'b1, 3'd4}));
    cycle();
    chk("ror_then_idle", 32'(op_valid), 32'(1'b0));

    // Back-to-back ADD, SUB, SLT with no bubbles
    n = 0;
    send(2'b10, 6'b000000, 3'd0, 4'b0010, 1, 1'b0, w); n += w;
    send(2'b10, 6'b000010, 3'd0, 4'b0110, 1, 1'b0, w); n += w;
    chk("b2b_sub_presented", 32'({op_valid, operation}), 32'({1'b1, 4'b0110}));
    send(2'b10, 6'b001010, 3'd0, 4'b0111, 1, 1'b0, w); n += w;
    chk("b2b_no_stall", 32'(n), 32'(0));
    chk("b2b_slt_presented", 32'({op_valid, operation, last}), 32'({1'b1, 4'b0111, 1'b1}));
    cycle();

    // LS by 3 with the ALU stalling for two cycles on beat 1
    send(2'b10, 6'b111101, 3'd3, 4'b0011, 3, 1'b0, w);
    cycle();
    ready_force = 1'b0;
    #1;
    snap = {operation, last, beat_idx, illegal};
    chk("ls_stall_beat_idx", 32'(beat_idx), 32'(1));
    chk("ls_stall_in_ready", 32'(in_ready), 32'(1'b0));
    cycle();
    cycle();
    chk("ls_stall_hold", 32'({op_valid, operation, last, beat_idx, illegal}), 32'({1'b1, snap}));
    ready_force = 1'b1;
    cycle();
    chk("ls_last_beat", 32'({operation, last, beat_idx}), 32'({4'b0011, 1'b1, 3'd2}));
    cycle();
    chk("ls_done", 32'({op_valid, 1'(sbq.size() == 0)}), 32'({1'b0, 1'b1}));

    // Reserved alu_op
    send(2'b11, 6'b000000, 3'd0, ILL_OP, 1, ILL_BIT, w);
    chk("illegal_beat", 32'({operation, illegal, last}), 32'({ILL_OP, ILL_BIT, 1'b1}));
    cycle();
    repeat (2) cycle();
    chk("illegal_sticky", 32'(illegal_sticky), 32'(ILL_BIT));

    // SRS by 7 with reset pulsed while beat 3 is presented
    send(2'b10, 6'b111010, 3'd7, 4'b0100, 7, 1'b0, w);
    for (int k = 0; k < 20; k++) begin
      if (beat_idx == 3'd3) break;
      cycle();
    end
    chk("srs_reached_beat3", 32'(beat_idx), 32'(3));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("reset_mid_op", 32'({op_valid, in_ready, beat_idx, illegal_sticky}),
        32'({1'b0, 1'b1, 3'd0, 1'b0}));
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (op_valid) n++;
    end
    chk("reset_no_resume", 32'(n), 32'(0));

    // Table vectors with random ALU backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send(tbl[i].aop, tbl[i].fn, tbl[i].sh, tbl[i].eop, tbl[i].beats, tbl[i].eill, w);
    for (int t = 0; t < 300; t++) begin
      if (!op_valid && sbq.size() == 0) break;
      cycle();
    end
    chk("table_drain", 32'({op_valid, 1'(sbq.size() == 0)}), 32'({1'b0, 1'b1}));
    chk("table_sticky", 32'(illegal_sticky), 32'(ILL_BIT));
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
